// File: rtl/pong_game_core.sv
`timescale 1ns/1ps
// Pong game-state engine on a coarse tile grid: ball and paddle motion, collision,
// scoring and win detection, advanced once per video frame tick.
module pong_game_core #(
    parameter int GAME_WIDTH    = 40,
    parameter int GAME_HEIGHT   = 30,
    parameter int PADDLE_HEIGHT = 6,
    parameter int BALL_DIV      = 3,
    parameter int PADDLE_DIV    = 2,
    parameter int SCORE_WIDTH   = 4,
    parameter int WIN_SCORE     = 9
) (
    input  logic                           i_Clk,
    input  logic                           i_Reset,
    input  logic                           i_Frame_Tick,
    input  logic                           i_Game_Start,
    input  logic                           i_Paddle_Up_P1,
    input  logic                           i_Paddle_Dn_P1,
    input  logic                           i_Paddle_Up_P2,
    input  logic                           i_Paddle_Dn_P2,
    output logic [$clog2(GAME_WIDTH)-1:0]  o_Ball_X,
    output logic [$clog2(GAME_HEIGHT)-1:0] o_Ball_Y,
    output logic [$clog2(GAME_HEIGHT)-1:0] o_Paddle_Y_P1,
    output logic [$clog2(GAME_HEIGHT)-1:0] o_Paddle_Y_P2,
    output logic [SCORE_WIDTH-1:0]         o_Score_P1,
    output logic [SCORE_WIDTH-1:0]         o_Score_P2,
    output logic [1:0]                     o_State,
    output logic [1:0]                     o_Winner,
    output logic                           o_Point_Pulse
);
    localparam int XW = $clog2(GAME_WIDTH);
    localparam int YW = $clog2(GAME_HEIGHT);
    localparam int BW = $clog2(BALL_DIV + 1);
    localparam int PW = $clog2(PADDLE_DIV + 1);

    localparam logic [XW-1:0] X_CENTRE       = XW'(GAME_WIDTH / 2);
    localparam logic [XW-1:0] X_LEFT         = XW'(1);
    localparam logic [XW-1:0] X_RIGHT        = XW'(GAME_WIDTH - 2);
    localparam logic [XW-1:0] X_LEFT_BOUNCE  = XW'(2);
    localparam logic [XW-1:0] X_RIGHT_BOUNCE = XW'(GAME_WIDTH - 3);
    localparam logic [YW-1:0] Y_CENTRE       = YW'(GAME_HEIGHT / 2);
    localparam logic [YW-1:0] Y_BOTTOM       = YW'(GAME_HEIGHT - 1);
    localparam logic [YW-1:0] Y_BOUNCE       = YW'(GAME_HEIGHT - 2);
    localparam logic [YW-1:0] PAD_HOME       = YW'((GAME_HEIGHT - PADDLE_HEIGHT) / 2);
    localparam logic [YW-1:0] PAD_MAX        = YW'(GAME_HEIGHT - PADDLE_HEIGHT);
    localparam logic [BW-1:0] BALL_LAST      = BW'(BALL_DIV - 1);
    localparam logic [PW-1:0] PAD_LAST       = PW'(PADDLE_DIV - 1);
    localparam logic [SCORE_WIDTH-1:0] WIN   = SCORE_WIDTH'(WIN_SCORE);

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAME_OVER = 2'd2} state_t;

    state_t                 state;
    logic                   dir_right;
    logic                   dir_down;
    logic [BW-1:0]          ball_div;
    logic [PW-1:0]          pad_div;
    logic                   ball_step;
    logic                   pad_step;
    logic                   hit_p1;
    logic                   hit_p2;
    logic                   point_p1;
    logic                   point_p2;
    logic [XW-1:0]          next_x;
    logic                   next_right;
    logic [YW-1:0]          next_y;
    logic                   next_down;
    logic [SCORE_WIDTH-1:0] score_p1_inc;
    logic [SCORE_WIDTH-1:0] score_p2_inc;

    function automatic logic in_paddle(input logic [YW-1:0] y, input logic [YW-1:0] top);
        return (y >= top) && ({1'b0, y} <= {1'b0, top} + (YW+1)'(PADDLE_HEIGHT - 1));
    endfunction

    function automatic logic [YW-1:0] paddle_next(input logic [YW-1:0] y, input logic up,
                                                  input logic dn);
        if (up && !dn && y != '0)
            return y - 1'b1;
        if (dn && !up && y < PAD_MAX)
            return y + 1'b1;
        return y;
    endfunction

    assign o_State = state;

    always_comb begin
        ball_step    = (state == PLAY) && i_Frame_Tick && (ball_div == BALL_LAST);
        pad_step     = (state != GAME_OVER) && i_Frame_Tick && (pad_div == PAD_LAST);
        hit_p1       = in_paddle(o_Ball_Y, o_Paddle_Y_P1);
        hit_p2       = in_paddle(o_Ball_Y, o_Paddle_Y_P2);
        point_p1     = dir_right && (o_Ball_X == X_RIGHT) && !hit_p2;
        point_p2     = !dir_right && (o_Ball_X == X_LEFT) && !hit_p1;
        score_p1_inc = o_Score_P1 + 1'b1;
        score_p2_inc = o_Score_P2 + 1'b1;

        next_down = dir_down;
        next_y    = o_Ball_Y;
        if (!dir_down && o_Ball_Y == '0) begin
            next_down = 1'b1;
            next_y    = YW'(1);
        end else if (dir_down && o_Ball_Y == Y_BOTTOM) begin
            next_down = 1'b0;
            next_y    = Y_BOUNCE;
        end else begin
            next_y = dir_down ? o_Ball_Y + 1'b1 : o_Ball_Y - 1'b1;
        end

        // Edge columns only reach the bounce branch on a hit; misses are taken as points.
        next_right = dir_right;
        next_x     = o_Ball_X;
        if (!dir_right && o_Ball_X == X_LEFT) begin
            next_right = 1'b1;
            next_x     = X_LEFT_BOUNCE;
        end else if (dir_right && o_Ball_X == X_RIGHT) begin
            next_right = 1'b0;
            next_x     = X_RIGHT_BOUNCE;
        end else begin
            next_x = dir_right ? o_Ball_X + 1'b1 : o_Ball_X - 1'b1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state         <= IDLE;
            o_Ball_X      <= X_CENTRE;
            o_Ball_Y      <= Y_CENTRE;
            dir_right     <= 1'b1;
            dir_down      <= 1'b1;
            o_Paddle_Y_P1 <= PAD_HOME;
            o_Paddle_Y_P2 <= PAD_HOME;
            o_Score_P1    <= '0;
            o_Score_P2    <= '0;
            o_Winner      <= '0;
            o_Point_Pulse <= 1'b0;
            ball_div      <= '0;
            pad_div       <= '0;
        end else begin
            o_Point_Pulse <= 1'b0;
            if (i_Frame_Tick && state != GAME_OVER)
                pad_div <= pad_step ? '0 : pad_div + 1'b1;
            if (pad_step) begin
                o_Paddle_Y_P1 <= paddle_next(o_Paddle_Y_P1, i_Paddle_Up_P1, i_Paddle_Dn_P1);
                o_Paddle_Y_P2 <= paddle_next(o_Paddle_Y_P2, i_Paddle_Up_P2, i_Paddle_Dn_P2);
            end
            case (state)
                IDLE: begin
                    ball_div <= '0;
                    if (i_Game_Start)
                        state <= PLAY;
                end
                PLAY: begin
                    if (i_Frame_Tick)
                        ball_div <= ball_step ? '0 : ball_div + 1'b1;
                    if (ball_step) begin
                        dir_down <= next_down;
                        if (point_p1 || point_p2) begin
                            o_Ball_X      <= X_CENTRE;
                            o_Ball_Y      <= Y_CENTRE;
                            dir_right     <= point_p2;
                            o_Point_Pulse <= 1'b1;
                            if (point_p1) begin
                                o_Score_P1 <= score_p1_inc;
                                if (score_p1_inc == WIN) begin
                                    state    <= GAME_OVER;
                                    o_Winner <= 2'd1;
                                end else begin
                                    state <= IDLE;
                                end
                            end else begin
                                o_Score_P2 <= score_p2_inc;
                                if (score_p2_inc == WIN) begin
                                    state    <= GAME_OVER;
                                    o_Winner <= 2'd2;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end else begin
                            o_Ball_X  <= next_x;
                            o_Ball_Y  <= next_y;
                            dir_right <= next_right;
                        end
                    end
                end
                GAME_OVER: begin
                    if (i_Game_Start) begin
                        o_Score_P1    <= '0;
                        o_Score_P2    <= '0;
                        o_Winner      <= '0;
                        o_Ball_X      <= X_CENTRE;
                        o_Ball_Y      <= Y_CENTRE;
                        o_Paddle_Y_P1 <= PAD_HOME;
                        o_Paddle_Y_P2 <= PAD_HOME;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
